sync_fifo_flags: RTL and testbench

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags_if.sv | 48 ++++
 rtl/sync_fifo_flags.sv | 131 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flags_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_if
// Purpose : bundles the data/handshake and status signals of sync_fifo_flags.
//           Clock, asynchronous reset and the synchronous flush stay plain ports
//           on the FIFO itself.
// Modports:
//   master - the FIFO user: drives wr_en_i/wdata_i/rd_en_i, observes the rest
//   slave  - the FIFO: observes requests, drives read data, flags and errors
// Signals :
//   wr_en_i, wdata_i[WIDTH]   write request and data
//   rd_en_i                   read request
//   rdata_o[WIDTH]            registered read data
//   rd_valid_o                rdata_o was updated this cycle
//   full_o, empty_o           occupancy == DEPTH / == 0
//   almost_full_o             count_o >= AF_LEVEL
//   almost_empty_o            count_o <= AE_LEVEL
//   count_o[PTR_ADDR+1]       current occupancy
//   wr_error_o, rd_error_o    rejected write / rejected read
// -----------------------------------------------------------------------------
interface sync_fifo_flags_if #(
    parameter int WIDTH    = 8,
    parameter int PTR_ADDR = 4
) ();
    logic                wr_en_i;
    logic [WIDTH-1:0]    wdata_i;
    logic                rd_en_i;
    logic [WIDTH-1:0]    rdata_o;
    logic                rd_valid_o;
    logic                full_o;
    logic                empty_o;
    logic                almost_full_o;
    logic                almost_empty_o;
    logic [PTR_ADDR:0]   count_o;
    logic                wr_error_o;
    logic                rd_error_o;

    modport master (
        output wr_en_i, wdata_i, rd_en_i,
        input  rdata_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, wr_error_o, rd_error_o
    );

    modport slave (
        input  wr_en_i, wdata_i, rd_en_i,
        output rdata_o, rd_valid_o, full_o, empty_o, almost_full_o,
               almost_empty_o, count_o, wr_error_o, rd_error_o
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
// Purpose : single-clock FIFO with registered read data, occupancy count,
//           full/empty/almost-full/almost-empty flags and overflow/underflow
//           error flags.
// Ports   :
//   clk_i    rising-edge clock
//   rst_ni   asynchronous active-low reset (pointers, read data, status)
//   clr_i    synchronous flush; wins over read/write requests that cycle
//   fifo_if  sync_fifo_flags_if.slave: requests, read data, flags, errors
// Configuration:
//   SYNC_FIFO_STICKY_ERR_EN - when defined, wr_error_o/rd_error_o stay high
//   once set until clr_i or reset. When undefined they are one-cycle pulses.
// Notes   :
//   Pointers are PTR_ADDR+1 bits so that full (difference == DEPTH) and empty
//   (difference == 0) are distinguishable. Memory is never reset.
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int PTR_ADDR = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    sync_fifo_flags_if.slave    fifo_if
);

    localparam logic [PTR_ADDR:0] PTR_ZERO_C = {(PTR_ADDR+1){1'b0}};
    localparam logic [PTR_ADDR:0] PTR_ONE_C  = (PTR_ADDR+1)'(1);
    localparam logic [PTR_ADDR:0] DEPTH_C    = (PTR_ADDR+1)'(DEPTH);
    localparam logic [PTR_ADDR:0] AF_C       = (PTR_ADDR+1)'(AF_LEVEL);
    localparam logic [PTR_ADDR:0] AE_C       = (PTR_ADDR+1)'(AE_LEVEL);

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [PTR_ADDR:0] wr_ptr_r;
    logic [PTR_ADDR:0] rd_ptr_r;
    logic [WIDTH-1:0]  rdata_r;
    logic              rd_valid_r;
    logic              wr_error_r;
    logic              rd_error_r;

    logic [PTR_ADDR:0] count_s;
    logic              full_s;
    logic              empty_s;
    logic              wr_accept_s;
    logic              rd_accept_s;
    logic              wr_reject_s;
    logic              rd_reject_s;
    logic              wr_error_nxt_s;
    logic              rd_error_nxt_s;

    // Occupancy and flags: derived from the pointer difference only, which wraps modulo 2^(PTR_ADDR+1).
    always_comb begin
        count_s = wr_ptr_r - rd_ptr_r;
        full_s  = (count_s == DEPTH_C);
        empty_s = (count_s == PTR_ZERO_C);
    end

    // Accept/reject decisions use the flags as they stand before the edge.
    always_comb begin
        wr_accept_s = fifo_if.wr_en_i & ~full_s;
        rd_accept_s = fifo_if.rd_en_i & ~empty_s;
        wr_reject_s = fifo_if.wr_en_i &  full_s;
        rd_reject_s = fifo_if.rd_en_i &  empty_s;
    end

    // Next error-flag value: pulse per rejection, or accumulate in the sticky build.
    always_comb begin
`ifdef SYNC_FIFO_STICKY_ERR_EN
        wr_error_nxt_s = wr_error_r | wr_reject_s;
        rd_error_nxt_s = rd_error_r | rd_reject_s;
`else
        wr_error_nxt_s = wr_reject_s;
        rd_error_nxt_s = rd_reject_s;
`endif
    end

    // Storage array: written on accepted writes only; deliberately has no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clr_i && wr_accept_s) begin
            mem_r[wr_ptr_r[PTR_ADDR-1:0]] <= fifo_if.wdata_i;
        end
    end

    // Pointers, registered read data, read-valid strobe and error flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            rdata_r    <= {WIDTH{1'b0}};
            rd_valid_r <= 1'b0;
            wr_error_r <= 1'b0;
            rd_error_r <= 1'b0;
        end else if (clr_i) begin
            // Flush: requests this cycle are dropped silently; rdata_r is kept.
            wr_ptr_r   <= PTR_ZERO_C;
            rd_ptr_r   <= PTR_ZERO_C;
            rd_valid_r <= 1'b0;
            wr_error_r <= 1'b0;
            rd_error_r <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (rd_accept_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                rdata_r  <= mem_r[rd_ptr_r[PTR_ADDR-1:0]];
            end
            rd_valid_r <= rd_accept_s;
            wr_error_r <= wr_error_nxt_s;
            rd_error_r <= rd_error_nxt_s;
        end
    end

    // Output mapping onto the interface.
    always_comb begin
        fifo_if.count_o        = count_s;
        fifo_if.full_o         = full_s;
        fifo_if.empty_o        = empty_s;
        fifo_if.almost_full_o  = (count_s >= AF_C);
        fifo_if.almost_empty_o = (count_s <= AE_C);
        fifo_if.rdata_o        = rdata_r;
        fifo_if.rd_valid_o     = rd_valid_r;
        fifo_if.wr_error_o     = wr_error_r;
        fifo_if.rd_error_o     = rd_error_r;
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
// Purpose : self-checking bench for sync_fifo_flags (WIDTH=8, DEPTH=16,
//           AF_LEVEL=12, AE_LEVEL=4). A queue-based reference model predicts
//           each cycle's outputs; a monitor process compares them one clock
//           after the stimulus. Directed fill/drain/wrap/simultaneous/flush/
//           reset sequences are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

    typedef struct {
        logic [4:0] count;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic       rd_valid;
        logic [7:0] rdata;
        logic       wr_err;
        logic       rd_err;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clr;

    sync_fifo_flags_if #(.WIDTH(8), .PTR_ADDR(4)) bus ();

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH(16), .PTR_ADDR(4), .AF_LEVEL(12), .AE_LEVEL(4)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .clr_i   (clr),
        .fifo_if (bus)
    );

    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [7:0] mq [$];
    logic [7:0] m_rdata = 8'h00;
    logic       m_rv    = 1'b0;
    logic       m_we    = 1'b0;
    logic       m_re    = 1'b0;

    exp_t       exp_q  [$];
    logic [7:0] data_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model_view();
        exp_t e;
        int   n;
        n          = mq.size();
        e.count    = 5'(n);
        e.full     = (n == 16);
        e.empty    = (n == 0);
        e.af       = (n >= 12);
        e.ae       = (n <= 4);
        e.rd_valid = m_rv;
        e.rdata    = m_rdata;
        e.wr_err   = m_we;
        e.rd_err   = m_re;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the result of the next rising edge.
    task automatic step(input logic c, input logic w, input logic [7:0] d, input logic r);
        logic was_full;
        logic was_empty;
        logic wrej;
        logic rrej;
        @(negedge clk);
        clr         = c;
        bus.wr_en_i = w;
        bus.wdata_i = d;
        bus.rd_en_i = r;
        if (c) begin
            mq.delete();
            m_rv = 1'b0;
            m_we = 1'b0;
            m_re = 1'b0;
        end else begin
            was_full  = (mq.size() == 16);
            was_empty = (mq.size() == 0);
            wrej      = w && was_full;
            rrej      = r && was_empty;
            m_rv      = r && !was_empty;
            if (m_rv) begin
                m_rdata = mq.pop_front();
                data_q.push_back(m_rdata);
            end
            if (w && !was_full) mq.push_back(d);
`ifdef SYNC_FIFO_STICKY_ERR_EN
            m_we = m_we || wrej;
            m_re = m_re || rrej;
`else
            m_we = wrej;
            m_re = rrej;
`endif
        end
        exp_q.push_back(model_view());
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},    32'(bus.count_o),        32'd0);
        chk({tag, "_empty"},    32'(bus.empty_o),        32'd1);
        chk({tag, "_ae"},       32'(bus.almost_empty_o), 32'd1);
        chk({tag, "_full"},     32'(bus.full_o),         32'd0);
        chk({tag, "_af"},       32'(bus.almost_full_o),  32'd0);
        chk({tag, "_rdata"},    32'(bus.rdata_o),        32'd0);
        chk({tag, "_rd_valid"}, 32'(bus.rd_valid_o),     32'd0);
        chk({tag, "_wr_err"},   32'(bus.wr_error_o),     32'd0);
        chk({tag, "_rd_err"},   32'(bus.rd_error_o),     32'd0);
    endtask

    // Asynchronous reset asserted between clock edges, checked before any edge arrives.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_rst");
        mq.delete();
        m_rdata = 8'h00;
        m_rv    = 1'b0;
        m_we    = 1'b0;
        m_re    = 1'b0;
        @(negedge clk);
        clr         = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare status every cycle with a prediction; check read data whenever the DUT flags it valid.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count",    32'(bus.count_o),        32'(e.count));
                chk("full",     32'(bus.full_o),         32'(e.full));
                chk("empty",    32'(bus.empty_o),        32'(e.empty));
                chk("af",       32'(bus.almost_full_o),  32'(e.af));
                chk("ae",       32'(bus.almost_empty_o), 32'(e.ae));
                chk("rd_valid", 32'(bus.rd_valid_o),     32'(e.rd_valid));
                chk("rdata",    32'(bus.rdata_o),        32'(e.rdata));
                chk("wr_err",   32'(bus.wr_error_o),     32'(e.wr_err));
                chk("rd_err",   32'(bus.rd_error_o),     32'(e.rd_err));
                if (bus.rd_valid_o === 1'b1) begin
                    if (data_q.size() == 0) begin
                        chk("unexpected_read", 32'd1, 32'd0);
                    end else begin
                        chk("read_order", 32'(bus.rdata_o), 32'(data_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        clr         = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.wdata_i = 8'h00;
        bus.rd_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill 0x01..0x10, then overflow once
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        step(1'b0, 1'b1, 8'hEE, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Drain 16, then underflow once (rdata must hold 0x10)
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Wrap: 10 in/out moves the pointers, then a full round of 0xA0..0xAF
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous: at count 5, at full, at empty
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b1, 8'h88, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Flush at count 7 together with a write
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0);
        step(1'b1, 1'b1, 8'h99, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset mid-burst, then confirm old data is gone
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        async_reset();
        step(1'b0, 1'b1, 8'h5A, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 99) < 60),
                 8'($urandom),
                 ($urandom_range(0, 99) < 50));
        end
        step(1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #2;
        chk("exp_queue_drained",  32'(exp_q.size()),  32'd0);
        chk("data_queue_drained", 32'(data_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
